// File: rtl/mc_core.sv
// Multi-cycle RV32-subset core: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT with internal program and data memories.
// Optional feature: define MC_CORE_BRANCH_EN to make beq redirect the PC; otherwise beq is a 3-cycle no-op.
module mc_core #(
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 6,
    parameter int DMEM_AW = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_waddr,
    input  logic [31:0]        imem_wdata,
    output logic [IMEM_AW-1:0] pc_o,
    output logic [31:0]        instr_o,
    output logic [2:0]         state_o,
    output logic               retire_o,
    output logic [4:0]         wb_addr_o,
    output logic [XLEN-1:0]    wb_data_o,
    output logic               halted_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t              r_state;
    logic [31:0]         r_imem [2**IMEM_AW];
    logic [XLEN-1:0]     r_dmem [2**DMEM_AW];
    logic [XLEN-1:0]     r_rf   [32];
    logic [IMEM_AW-1:0]  r_pc;
    logic [31:0]         r_instr;
    logic [XLEN-1:0]     r_rs1v;
    logic [XLEN-1:0]     r_rs2v;
    logic [XLEN-1:0]     r_imm;
    logic [XLEN-1:0]     r_result;
    logic [DMEM_AW-1:0]  r_daddr;
    logic                r_retire;
    logic [4:0]          r_wb_addr;
    logic [XLEN-1:0]     r_wb_data;
    logic                r_halted;

    logic [6:0]          w_opcode;
    logic [4:0]          w_rd;
    logic [4:0]          w_rs1;
    logic [4:0]          w_rs2;
    logic [2:0]          w_funct3;
    logic                w_funct7_5;
    logic                w_is_r;
    logic                w_is_addi;
    logic                w_is_lw;
    logic                w_is_sw;
    logic                w_is_beq;
    logic                w_valid;
    logic [XLEN-1:0]     w_imm_i;
    logic [XLEN-1:0]     w_imm_s;
    logic [XLEN-1:0]     w_imm_b;
    logic [XLEN-1:0]     w_imm;
    logic [XLEN-1:0]     w_rs1_data;
    logic [XLEN-1:0]     w_rs2_data;
    logic [XLEN-1:0]     w_alu_b;
    logic [XLEN-1:0]     w_alu;
    logic [IMEM_AW-1:0]  w_pc_inc;
    logic [IMEM_AW-1:0]  w_pc_br;

    assign w_opcode   = r_instr[6:0];
    assign w_rd       = r_instr[11:7];
    assign w_funct3   = r_instr[14:12];
    assign w_rs1      = r_instr[19:15];
    assign w_rs2      = r_instr[24:20];
    assign w_funct7_5 = r_instr[30];

    assign w_is_r    = (w_opcode == OP_R);
    assign w_is_addi = (w_opcode == OP_ADDI);
    assign w_is_lw   = (w_opcode == OP_LW);
    assign w_is_sw   = (w_opcode == OP_SW);
    assign w_is_beq  = (w_opcode == OP_BEQ);
    assign w_valid   = w_is_r | w_is_addi | w_is_lw | w_is_sw | w_is_beq;

    assign w_imm_i = {{(XLEN-12){r_instr[31]}}, r_instr[31:20]};
    assign w_imm_s = {{(XLEN-12){r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
    assign w_imm_b = {{(XLEN-13){r_instr[31]}}, r_instr[31], r_instr[7],
                      r_instr[30:25], r_instr[11:8], 1'b0};

    always_comb begin
        w_imm = w_imm_i;
        if (w_is_sw)  w_imm = w_imm_s;
        if (w_is_beq) w_imm = w_imm_b;
    end

    assign w_rs1_data = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
    assign w_rs2_data = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2];

    // Non-R instructions (addi, lw/sw address) all use rs1 + imm.
    assign w_alu_b = w_is_r ? r_rs2v : r_imm;
    always_comb begin
        w_alu = r_rs1v + w_alu_b;
        if (w_is_r) begin
            case (w_funct3)
                3'b111:  w_alu = r_rs1v & r_rs2v;
                3'b110:  w_alu = r_rs1v | r_rs2v;
                default: w_alu = w_funct7_5 ? (r_rs1v - r_rs2v) : (r_rs1v + r_rs2v);
            endcase
        end
    end

    assign w_pc_inc = r_pc + IMEM_AW'(1);

`ifdef MC_CORE_BRANCH_EN
    // Byte offset >>> 2 gives a word offset; truncation to IMEM_AW bits wraps the PC.
    assign w_pc_br = (r_rs1v == r_rs2v) ? (r_pc + r_imm[IMEM_AW+1:2]) : w_pc_inc;
`else
    assign w_pc_br = w_pc_inc;
`endif

    always_ff @(posedge clk) begin
        if (imem_we && (r_state == S_IDLE))
            r_imem[imem_waddr] <= imem_wdata;
    end

    always_ff @(posedge clk) begin
        if ((r_state == S_MEM) && w_is_sw)
            r_dmem[r_daddr] <= r_rs2v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_instr   <= '0;
            r_rs1v    <= '0;
            r_rs2v    <= '0;
            r_imm     <= '0;
            r_result  <= '0;
            r_daddr   <= '0;
            r_retire  <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
            r_halted  <= 1'b0;
            r_rf      <= '{default: '0};
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_instr <= r_imem[r_pc];
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_rs1v <= w_rs1_data;
                    r_rs2v <= w_rs2_data;
                    r_imm  <= w_imm;
                    if (w_valid) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_is_beq) begin
                        r_pc     <= w_pc_br;
                        r_retire <= 1'b1;
                        r_state  <= S_FETCH;
                    end else begin
                        r_result <= w_alu;
                        r_daddr  <= w_alu[DMEM_AW+1:2];
                        r_state  <= (w_is_lw || w_is_sw) ? S_MEM : S_WB;
                    end
                end
                S_MEM: begin
                    if (w_is_lw) begin
                        r_result <= r_dmem[r_daddr];
                        r_state  <= S_WB;
                    end else begin
                        r_pc     <= w_pc_inc;
                        r_retire <= 1'b1;
                        r_state  <= S_FETCH;
                    end
                end
                S_WB: begin
                    if (w_rd != 5'd0) begin
                        r_rf[w_rd] <= r_result;
                        r_wb_addr  <= w_rd;
                        r_wb_data  <= r_result;
                    end
                    r_pc     <= w_pc_inc;
                    r_retire <= 1'b1;
                    r_state  <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pc_o      = r_pc;
    assign instr_o   = r_instr;
    assign state_o   = r_state;
    assign retire_o  = r_retire;
    assign wb_addr_o = r_wb_addr;
    assign wb_data_o = r_wb_data;
    assign halted_o  = r_halted;

endmodule

// File: doc/mc_core.md
MC_CORE -- requirements
Module: mc_core

Interface
REQ-001 Parameter XLEN, default 32: datapath and register width; instructions stay 32 bits.
REQ-002 Parameter IMEM_AW, default 6: program-memory word-address width (2**IMEM_AW words).
REQ-003 Parameter DMEM_AW, default 6: data-memory word-address width (2**DMEM_AW words).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 run  in  1  level; leaves IDLE when high.
REQ-007 imem_we  in  1  program-load write strobe.
REQ-008 imem_waddr  in  IMEM_AW  program-load word address.
REQ-009 imem_wdata  in  32  program-load instruction word.
REQ-010 pc_o  out  IMEM_AW  current word PC.
REQ-011 instr_o  out  32  instruction register contents.
REQ-012 state_o  out  3  FSM state encoding.
REQ-013 retire_o  out  1  one-cycle pulse when an instruction completes.
REQ-014 wb_addr_o  out  5  destination register of the last register write.
REQ-015 wb_data_o  out  XLEN  data of the last register write.
REQ-016 halted_o  out  1  high while in HALT.

Function
REQ-017 FSM states SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
REQ-018 IDLE SHALL go to FETCH when run=1; imem writes SHALL be accepted only in IDLE and ignored elsewhere.
REQ-019 FETCH SHALL latch imem[pc_o] into instr_o; DECODE SHALL latch rs1/rs2 data and the sign-extended immediate.
REQ-020 Supported: R-type add/sub/and/or (opcode 0110011), addi (0010011), lw (0000011), sw (0100011), beq (1100011); funct7[5] selects sub.
REQ-021 Any other opcode, including all-zero words, SHALL go DECODE->HALT without retiring; HALT SHALL hold until reset.
REQ-022 Sequences: R/addi F-D-E-WB (4 cycles); lw F-D-E-M-WB (5); sw F-D-E-M (4); beq F-D-E (3); then FETCH.
REQ-023 retire_o SHALL pulse in the last state of each sequence; PC SHALL update on that same edge.
REQ-024 Non-branch PC SHALL be pc_o+1 modulo 2**IMEM_AW.
REQ-025 Data address SHALL be (rs1+imm)[DMEM_AW+1:2]; low two bits ignored; higher bits truncated.
REQ-026 Register x0 SHALL read zero; writes to x0 SHALL be discarded but still retire, and wb_addr_o/wb_data_o SHALL not update.
REQ-027 Arithmetic SHALL wrap modulo 2**XLEN with no overflow flag.
REQ-028 run deasserted mid-instruction SHALL be ignored; the core stops only by HALT or reset.

Reset
REQ-029 On rst: state IDLE, pc_o 0, instr_o 0, retire_o 0, wb_addr_o 0, wb_data_o 0, halted_o 0, all registers 0.
REQ-030 Program and data memory contents SHALL be unaffected by reset.
REQ-031 Reset asserted in any state SHALL abort the instruction with no register or memory write after the asserting edge.

Configuration
REQ-032 Macro MC_CORE_BRANCH_EN defined: beq taken when rs1==rs2, next PC = pc_o + (B-immediate >>> 2) modulo 2**IMEM_AW; else pc_o+1.
REQ-033 Macro MC_CORE_BRANCH_EN undefined: beq SHALL execute as 3-cycle no-op with next PC pc_o+1 and still retire.

Verification
REQ-034 Load addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; run=1 -> wb x3=12 after 12 cycles, three retire pulses.
REQ-035 sw x3,8(x0) then lw x4,8(x0) -> wb x4=12; lw retire exactly 5 cycles after its FETCH.
REQ-036 addi x0,x0,9 -> retire pulses, wb_addr_o unchanged, x0 reads 0.
REQ-037 beq x1,x1,-8 at pc 4 -> with MC_CORE_BRANCH_EN pc_o=2; without, pc_o=5.
REQ-038 Word 0x00000000 at pc 3 -> HALT, halted_o=1, no retire; imem_we ignored; rst returns IDLE, pc_o=0.
REQ-039 rst asserted during MEM of sw -> target data word unchanged, all outputs at reset values.
